btn_event_decoder: RTL and testbench
====================================

Name: btn_event_decoder

Overview:
- Sits directly downstream of the button debouncer.
- The debouncer's output toggles once per debounced transition; it starts at 0 with the button released, so odd toggles are presses and even toggles are releases.
- This block turns that toggle stream into single-cycle press, release, long-press and auto-repeat strobes, plus a level and a press counter, for the game control logic.

Parameters:
- LONG_CYCLES, 50000000, hold cycles after press before long_pulse (1 s at 50 MHz); minimum 2
- REPEAT_CYCLES, 10000000, cycles between repeat_pulse strobes while held (200 ms); minimum 2
- CNT_W, 26, width of the hold counter; must hold max(LONG_CYCLES, REPEAT_CYCLES)-1
- EVT_W, 8, width of event_count

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- btn_toggle  in  1  debounced toggle from the debouncer, synchronous to clk
- btn_level  out  1  decoded pressed state, 1 = pressed
- press_pulse  out  1  one-cycle strobe on press
- release_pulse  out  1  one-cycle strobe on release
- long_pulse  out  1  one-cycle strobe when a press reaches LONG_CYCLES
- repeat_pulse  out  1  one-cycle strobe every REPEAT_CYCLES after long_pulse while held
- event_count  out  EVT_W  number of presses since reset, modulo 2^EVT_W

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, hold_cnt=0, event_count=0.
  - All pulses=0, btn_level=0.
  - tgl_q loads the current btn_toggle (re-baseline), so no event is generated on reset release.
  - A button held across reset is treated as released; its later release is decoded as a press. This is the required behaviour.
- Edge detect: evt = btn_toggle XOR tgl_q; tgl_q <= btn_toggle every non-reset edge.
- All outputs are registered. Pulses are high exactly one cycle and default to 0 every cycle.
- IDLE:
  - evt at edge E0: press_pulse=1, btn_level=1, event_count+1 (wraps from all-ones to 0), hold_cnt=0, go to PRESSED.
- PRESSED:
  - evt: release_pulse=1, btn_level=0, go to IDLE.
  - Else, if hold_cnt==LONG_CYCLES-1: long_pulse=1, hold_cnt=0, go to HELD. long_pulse is therefore high in the cycle after edge E0+LONG_CYCLES.
  - Else hold_cnt+1.
- HELD:
  - evt: release_pulse=1, btn_level=0, go to IDLE.
  - Else, if hold_cnt==REPEAT_CYCLES-1: repeat_pulse=1, hold_cnt=0. The first repeat follows edge E0+LONG_CYCLES+REPEAT_CYCLES, then one every REPEAT_CYCLES.
  - Else hold_cnt+1.
- Simultaneous evt and threshold on the same edge: evt wins. Only release_pulse fires; no long_pulse or repeat_pulse.
- At most one pulse output is high in any cycle.
- Toggles on consecutive cycles are each decoded; no event is dropped.
- Reset mid-hold: aborts immediately with no release_pulse.

Optional Feature:
- Macro BTN_EVT_REPEAT_EN.
- Defined: HELD generates repeat_pulse as described above.
- Undefined:
  - repeat_pulse is tied to 0.
  - hold_cnt is held at 0 in HELD.
  - HELD waits only for evt (release).
  - All other behaviour is identical.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, EVT_W=4):
- Reset then idle for 20 cycles, btn_toggle constant -> all pulses 0, btn_level 0, event_count 0.
- btn_toggle 0->1 at E0, 1->0 at E0+3 -> press_pulse after E0; release_pulse after E0+3; no long_pulse; event_count=1; btn_level 1 during cycles E0..E0+2.
- btn_toggle 0->1 held 20 cycles (BTN_EVT_REPEAT_EN defined) -> long_pulse after E0+8; repeat_pulse after E0+12, E0+16, E0+20; release_pulse on toggle back.
- Same as previous, but toggle back exactly at E0+8 -> release_pulse only; no long_pulse.
- 17 press/release pairs -> event_count wraps to 1.
- rst_n low for 1 cycle at E0+5 of a press, with btn_toggle held at 1 -> all outputs 0 and no event after reset; next toggle 1->0 yields press_pulse and event_count=1.

Source files
------------

// File: rtl/btn_event_decoder_if.sv
// Button event bus between the toggle source and btn_event_decoder.
// master drives the debounced toggle; slave returns the decoded events.
interface btn_event_decoder_if #(
  parameter int EVT_W = 8
);
  logic             btn_toggle;
  logic             btn_level;
  logic             press_pulse;
  logic             release_pulse;
  logic             long_pulse;
  logic             repeat_pulse;
  logic [EVT_W-1:0] event_count;

  modport master (
    output btn_toggle,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  event_count
  );

  modport slave (
    input  btn_toggle,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output event_count
  );
endinterface

// File: rtl/btn_event_decoder.sv
// Debounced toggle stream -> press/release/long/repeat strobes + counter.
// Define BTN_EVT_REPEAT_EN to enable auto-repeat strobes while held.
module btn_event_decoder #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26,
  parameter int EVT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  btn_event_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES - 1);
`endif

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("btn_event_decoder: cycle parameters must be >= 2");
  end

  state_t           state, state_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [EVT_W-1:0] evt_cnt, evt_cnt_d;
  logic             tgl_q;
  logic             level, level_d;
  logic             press, press_d;
  logic             rel, rel_d;
  logic             lng, lng_d;
  logic             rep, rep_d;
  logic             evt;

  assign evt = bus.btn_toggle ^ tgl_q;

  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    evt_cnt_d  = evt_cnt;
    level_d    = level;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    lng_d      = 1'b0;
    rep_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (evt) begin
          press_d    = 1'b1;
          level_d    = 1'b1;
          evt_cnt_d  = evt_cnt + 1'b1;
          hold_cnt_d = '0;
          state_d    = PRESSED;
        end
      end
      PRESSED: begin
        if (evt) begin
          rel_d      = 1'b1;
          level_d    = 1'b0;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if (hold_cnt == LONG_MAX) begin
          lng_d      = 1'b1;
          hold_cnt_d = '0;
          state_d    = HELD;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      HELD: begin
        if (evt) begin
          rel_d      = 1'b1;
          level_d    = 1'b0;
          hold_cnt_d = '0;
          state_d    = IDLE;
`ifdef BTN_EVT_REPEAT_EN
        end else if (hold_cnt == REP_MAX) begin
          rep_d      = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
`else
        end else begin
          hold_cnt_d = '0;
        end
`endif
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
        level_d    = 1'b0;
      end
    endcase
  end

  // Reset re-baselines tgl_q so a held button produces no event on release of reset.
  always_ff @(posedge clk) begin
    tgl_q <= bus.btn_toggle;
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      evt_cnt  <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      rel      <= 1'b0;
      lng      <= 1'b0;
      rep      <= 1'b0;
    end else begin
      state    <= state_d;
      hold_cnt <= hold_cnt_d;
      evt_cnt  <= evt_cnt_d;
      level    <= level_d;
      press    <= press_d;
      rel      <= rel_d;
      lng      <= lng_d;
      rep      <= rep_d;
    end
  end

  assign bus.btn_level     = level;
  assign bus.press_pulse   = press;
  assign bus.release_pulse = rel;
  assign bus.long_pulse    = lng;
  assign bus.repeat_pulse  = rep;
  assign bus.event_count   = evt_cnt;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench for btn_event_decoder: directed plan plus random toggles.
// Expected outputs come from a press-age model; a negedge monitor compares.
module tb_btn_event_decoder;

  localparam int L  = 8;
  localparam int R  = 4;
  localparam int EW = 4;

  typedef struct packed {
    logic          lvl;
    logic          pr;
    logic          rl;
    logic          lg;
    logic          rp;
    logic [EW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_event_decoder_if #(.EVT_W(EW)) bif ();

  btn_event_decoder #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (4),
    .EVT_W        (EW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  bit   m_pressed = 0;
  int   m_age     = 0;
  logic m_prev    = 1'b0;
  int   m_cnt     = 0;
  logic t         = 1'b0;

  // Model: age counts edges since the press edge.
  task automatic step(input logic tog, input logic rst);
    exp_t e;
    bit   ev;
    bif.btn_toggle = tog;
    rst_n = rst;
    @(posedge clk);
    e = '0;
    if (!rst) begin
      m_pressed = 0;
      m_age     = 0;
      m_cnt     = 0;
    end else begin
      ev = (tog != m_prev);
      if (ev && !m_pressed) begin
        e.pr      = 1'b1;
        m_pressed = 1;
        m_age     = 0;
        m_cnt     = m_cnt + 1;
      end else if (ev) begin
        e.rl      = 1'b1;
        m_pressed = 0;
      end else if (m_pressed) begin
        m_age = m_age + 1;
        if (m_age == L) e.lg = 1'b1;
`ifdef BTN_EVT_REPEAT_EN
        if (m_age > L && (m_age - L) % R == 0) e.rp = 1'b1;
`endif
      end
    end
    m_prev = tog;
    e.lvl  = m_pressed;
    e.cnt  = EW'(m_cnt % (1 << EW));
    q.push_back(e);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(t, 1'b1);
  endtask

  task automatic flip();
    t = ~t;
    step(t, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g.lvl = bif.btn_level;
      g.pr  = bif.press_pulse;
      g.rl  = bif.release_pulse;
      g.lg  = bif.long_pulse;
      g.rp  = bif.repeat_pulse;
      g.cnt = bif.event_count;
      checks++;
      if (g === e) passes++;
      else
        $display("FAIL cycle%0d got lvl%b pr%b rl%b lg%b rp%b cnt%0d exp lvl%b pr%b rl%b lg%b rp%b cnt%0d",
                 cyc, g.lvl, g.pr, g.rl, g.lg, g.rp, g.cnt,
                 e.lvl, e.pr, e.rl, e.lg, e.rp, e.cnt);
      cyc++;
    end
  end

  initial begin
    bif.btn_toggle = 1'b0;
    step(t, 1'b0);
    step(t, 1'b0);
    hold(20);

    // short press/release
    flip();
    hold(2);
    flip();
    hold(5);

    // long hold with repeats
    flip();
    hold(20);
    flip();
    hold(3);

    // release exactly on the long threshold
    flip();
    hold(L - 1);
    flip();
    hold(3);

    // counter wrap
    for (int i = 0; i < 17; i++) begin
      flip();
      hold(1);
      flip();
      hold(1);
    end
    hold(2);

    // reset mid-hold, then re-baselined toggle
    step(t, 1'b0);
    flip();
    hold(4);
    step(t, 1'b0);
    hold(5);
    flip();
    hold(3);
    flip();
    hold(2);

    // back-to-back toggles
    for (int i = 0; i < 6; i++) flip();
    hold(2);

    // random segments: sparse toggles give long holds, dense toggles stress edges
    for (int s = 0; s < 30; s++) begin
      int p;
      p = (s % 2 == 0) ? 3 : 35;
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 99) < p) t = ~t;
        step(t, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
      end
    end

    hold(3);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain left %0d required 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
